if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipelined core.
- Keeps the PC and issues single-outstanding requests to instruction memory, which has variable latency.
- Registers the returned word as instrD and presents the raw immediate fields (iimm, simm, bimm, uimm, jimm, iimm_shamt) to the downstream immediate extender and decoder.
- Handles ID stall, ID flush and branch/jump redirect.

---
 rtl/core_pkg.sv | 38 +++
 rtl/ifid_reg.sv | 49 ++++
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipelined core: fetch FSM states,
// bubble encoding, base opcodes, immediate-select codes and PC helper.
package core_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2,
    F_HOLD = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 used as the pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate-select encodings understood by the immediate extender
  localparam logic [2:0] IMM_ITYPE = 3'b010;
  localparam logic [2:0] IMM_STYPE = 3'b001;

  // Sequential fetch address; wraps modulo 2^32
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush, then stall (hold), then load,
// otherwise a bubble is inserted.
module ifid_reg
#(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_load_instr,
  input  logic [31:0] i_load_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);
  import core_pkg::*;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // IF -> ID boundary: flush beats stall, stall beats load; pcD survives a flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        r_instr <= i_load_instr;
        r_pc    <= i_load_pc;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding fetch sequencer against a
// variable-latency instruction memory, one-word hold buffer for ID stalls,
// redirect handling, and the IF/ID register with raw immediate slices.
module if_stage
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic        validD,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [4:0]  iimm_shamt
);
  import core_pkg::*;

  fetch_state_e r_state;
  logic [31:0]  r_pc_f;
  logic         r_drop;
  logic [31:0]  r_buf;

  logic         w_rsp;
  logic         w_take_mem;
  logic         w_take_buf;
  logic         w_to_hold;
  logic         w_load;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_redirect_pc;
  logic         w_unused;

  // A response only counts while a request is outstanding
  assign w_rsp      = (r_state == F_WAIT) && imem_rvalid;
  assign w_take_mem = w_rsp && !r_drop && !stallD && !redirect_valid;
  assign w_to_hold  = w_rsp && !r_drop &&  stallD && !redirect_valid;
  assign w_take_buf = (r_state == F_HOLD) && !stallD && !redirect_valid;
  assign w_load       = w_take_mem || w_take_buf;
  assign w_load_instr = w_take_buf ? r_buf : imem_rdata;

  // Targets are word aligned; the two low bits are dropped
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirect_pc[1:0]};

  assign imem_req  = (r_state == F_REQ);
  assign imem_addr = r_pc_f;

  // Fetch sequencer: redirect overrides every state transition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= F_IDLE;
      r_pc_f  <= RESET_PC;
      r_drop  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc_f <= w_redirect_pc;
      case (r_state)
        F_IDLE: r_state <= F_REQ;
        F_REQ: begin
          // the request at the old PC still goes out; its reply is discarded
          r_state <= F_WAIT;
          r_drop  <= 1'b1;
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            r_state <= F_REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        F_HOLD:  r_state <= F_REQ;
        default: r_state <= F_IDLE;
      endcase
    end else begin
      case (r_state)
        F_IDLE: r_state <= F_REQ;
        F_REQ:  r_state <= F_WAIT;
        F_WAIT: begin
          if (imem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= F_REQ;
            end else if (!stallD) begin
              r_pc_f  <= pc_next(r_pc_f);
              r_state <= F_REQ;
            end else begin
              r_state <= F_HOLD;
            end
          end
        end
        F_HOLD: begin
          if (!stallD) begin
            r_pc_f  <= pc_next(r_pc_f);
            r_state <= F_REQ;
          end
        end
        default: r_state <= F_IDLE;
      endcase
    end
  end

  // Hold buffer captures a word that arrives while ID is stalled
  always_ff @(posedge clk) begin
    if (w_to_hold) begin
      r_buf <= imem_rdata;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk          (clk),
    .rstn         (rstn),
    .i_flush      (flushD || redirect_valid),
    .i_stall      (stallD),
    .i_load       (w_load),
    .i_load_instr (w_load_instr),
    .i_load_pc    (r_pc_f),
    .o_instr      (instrD),
    .o_pc         (pcD),
    .o_valid      (validD)
  );

  // Raw immediate fields for the extender and decoder
  assign iimm       = instrD[31:20];
  assign simm       = {instrD[31:25], instrD[11:7]};
  assign bimm       = {instrD[31], instrD[7], instrD[30:25], instrD[11:8]};
  assign uimm       = instrD[31:12];
  assign jimm       = {instrD[31], instrD[19:12], instrD[20], instrD[30:21]};
  assign iimm_shamt = instrD[24:20];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed sequences around a variable-latency
// instruction memory model plus a table of decoded-field vectors.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm;
  logic [4:0]  iimm_shamt;

  if_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .stallD         (stallD),
    .flushD         (flushD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pcD            (pcD),
    .instrD         (instrD),
    .validD         (validD),
    .iimm           (iimm),
    .simm           (simm),
    .bimm           (bimm),
    .uimm           (uimm),
    .jimm           (jimm),
    .iimm_shamt     (iimm_shamt)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] p_addr = '0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        h_rvalid = 1'b0;
  logic [31:0] h_rdata = '0;
  bit          mem_auto = 1'b1;
  logic [31:0] req_log [$];

  assign imem_rvalid = mem_auto ? m_rvalid : h_rvalid;
  assign imem_rdata  = mem_auto ? m_rdata  : h_rdata;

  always @(negedge clk) begin
    m_rvalid = 1'b0;
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = mem[p_addr[9:2]];
          pend     = 1'b0;
        end
      end
      if (imem_req) begin
        req_log.push_back(imem_addr);
        pend   = 1'b1;
        cnt    = lat;
        p_addr = imem_addr;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (validD !== 1'b1 && n < maxc);
    if (validD !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: validD not seen within %0d cycles", nm, maxc);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [4:0]  shamt;
  } vec_t;

  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          idx;

    vt[0] = '{32'h00500093, 32'h40, 12'h005, 12'h001, 12'h400, 20'h00500, 20'h00402, 5'd5};
    vt[1] = '{32'hFE112E23, 32'h44, 12'hFE1, 12'hFFC, 12'hBFE, 20'hFE112, 20'h897F0, 5'd1};
    vt[2] = '{32'hFE000EE3, 32'h48, 12'hFE0, 12'hFFD, 12'hFFE, 20'hFE000, 20'h803F0, 5'd0};
    vt[3] = '{32'h00A00113, 32'h4C, 12'h00A, 12'h002, 12'h001, 20'h00A00, 20'h00005, 5'd10};

    for (int i = 0; i < 256; i++) begin
      a = 32'(i) << 2;
      mem[i] = {a[19:0], 12'h037};
    end
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    mem[2] = 32'hFE112E23;
    mem[3] = 32'hFE000EE3;
    for (int i = 0; i < 4; i++) mem[16 + i] = vt[i].word;

    // asynchronous reset before any clock edge
    #2 rstn = 1'b0;
    #1;
    chk("rst_instrD", instrD, 32'h00000013);
    chk("rst_validD", 32'(validD), 32'd0);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_iimm", 32'(iimm), 32'h000);
    #19 rstn = 1'b1;

    // first fetches, latency 1
    wait_valid("s1_first", 10);
    chk("s1_instrD", instrD, 32'h00500093);
    chk("s1_pcD", pcD, 32'h0);
    chk("s1_iimm", 32'(iimm), 32'h005);
    chk("s1_shamt", 32'(iimm_shamt), 32'd5);
    chk("s1_addr0", req_log[0], 32'h0);
    tick();
    chk("s1_bubble_valid", 32'(validD), 32'd0);
    chk("s1_bubble_instr", instrD, 32'h00000013);
    wait_valid("s1_second", 10);
    chk("s1_instr2", instrD, 32'h00A00113);
    chk("s1_pc2", pcD, 32'h4);
    chk("s1_addr1", req_log[1], 32'h4);

    // three stalled cycles while the word for 0x8 returns
    stallD = 1'b1;
    repeat (3) tick();
    chk("st_hold_instr", instrD, 32'h00A00113);
    chk("st_hold_pc", pcD, 32'h4);
    chk("st_hold_valid", 32'(validD), 32'd1);
    chk("st_nreq", 32'(req_log.size()), 32'd3);
    chk("st_addr2", req_log[2], 32'h8);
    stallD = 1'b0;
    tick();
    chk("st_rel_instr", instrD, 32'hFE112E23);
    chk("st_rel_pc", pcD, 32'h8);
    chk("st_rel_valid", 32'(validD), 32'd1);
    chk("st_simm", 32'(simm), 32'hFFC);
    wait_valid("st_next", 10);
    chk("st_addr3", req_log[3], 32'hC);
    chk("br_instr", instrD, 32'hFE000EE3);
    chk("br_pc", pcD, 32'hC);
    chk("br_bimm", 32'(bimm), 32'hFFE);

    // redirect while waiting on a 3-cycle response
    lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(validD), 32'd0);
    wait_valid("rd_target", 20);
    chk("rd_pc", pcD, 32'h100);
    chk("rd_instr", instrD, 32'h00100037);
    chk("rd_addr_old", req_log[4], 32'h10);
    chk("rd_addr_new", req_log[5], 32'h100);
    chk("rd_nreq", 32'(req_log.size()), 32'd6);

    // flush together with stall
    lat = 1;
    flushD = 1'b1;
    stallD = 1'b1;
    tick();
    flushD = 1'b0;
    stallD = 1'b0;
    chk("fs_instr", instrD, 32'h00000013);
    chk("fs_valid", 32'(validD), 32'd0);
    chk("fs_pc_kept", pcD, 32'h100);
    wait_valid("fs_pending", 10);
    chk("fs_next_pc", pcD, 32'h104);
    chk("fs_next_instr", instrD, 32'h00104037);

    // misaligned redirect taken while a request is going out
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("ma_valid", 32'(validD), 32'd0);
    wait_valid("ma_target", 20);
    chk("ma_old_req", req_log[7], 32'h108);
    chk("ma_addr", req_log[8], 32'h200);
    chk("ma_nreq", 32'(req_log.size()), 32'd9);
    chk("ma_pc", pcD, 32'h200);
    chk("ma_instr", instrD, 32'h00200037);

    // field-vector table fetched sequentially from 0x40
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("tv%0d_valid", i), 20);
      chk($sformatf("tv%0d_instr", i), instrD, vt[i].word);
      chk($sformatf("tv%0d_pc", i), pcD, vt[i].pc);
      chk($sformatf("tv%0d_iimm", i), 32'(iimm), 32'(vt[i].iimm));
      chk($sformatf("tv%0d_simm", i), 32'(simm), 32'(vt[i].simm));
      chk($sformatf("tv%0d_bimm", i), 32'(bimm), 32'(vt[i].bimm));
      chk($sformatf("tv%0d_uimm", i), 32'(uimm), 32'(vt[i].uimm));
      chk($sformatf("tv%0d_jimm", i), 32'(jimm), 32'(vt[i].jimm));
      chk($sformatf("tv%0d_shamt", i), 32'(iimm_shamt), 32'(vt[i].shamt));
    end

    // reset pulsed while waiting, with a stale response afterwards
    stallD   = 1'b1;
    mem_auto = 1'b0;
    tick();
    tick();
    chk("rr_pre_instr", instrD, vt[3].word);
    chk("rr_pre_valid", 32'(validD), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rr_instr", instrD, 32'h00000013);
    chk("rr_valid", 32'(validD), 32'd0);
    chk("rr_pc", pcD, 32'h0);
    chk("rr_req", 32'(imem_req), 32'd0);
    chk("rr_jimm", 32'(jimm), 32'h0);
    stallD   = 1'b0;
    h_rvalid = 1'b1;
    h_rdata  = 32'hDEADBEEF;
    @(posedge clk);
    #3 rstn = 1'b1;
    idx = req_log.size();
    tick();
    h_rvalid = 1'b0;
    mem_auto = 1'b1;
    chk("rr_stale_valid", 32'(validD), 32'd0);
    wait_valid("rr_first", 10);
    chk("rr_first_addr", req_log[idx], 32'h0);
    chk("rr_first_pc", pcD, 32'h0);
    chk("rr_first_instr", instrD, 32'h00500093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
